// File: rtl/nested_assoc_reader_pkg.sv
// Shared types for the nested associative-array reader: read ops, FSM states,
// slot payload and the lexicographic {k1,k2} key ordering.
package nested_assoc_pkg;

    localparam int unsigned K1W = 32;
    localparam int unsigned K2W = 64;
    localparam int unsigned DW  = 32;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FIRST  = 2'd1,
        OP_NEXT   = 2'd2,
        OP_RSVD   = 2'd3
    } rd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic           valid;
        logic [K1W-1:0] k1;
        logic [K2W-1:0] k2;
        logic [DW-1:0]  data;
    } entry_t;

    // Unsigned compare with k1 as the most-significant part.
    function automatic logic key_gt(input logic [K1W-1:0] k1a, input logic [K2W-1:0] k2a,
                                    input logic [K1W-1:0] k1b, input logic [K2W-1:0] k2b);
        return {k1a, k2a} > {k1b, k2b};
    endfunction

endpackage

// File: rtl/nested_assoc_reader_if.sv
// Write, read-request and response channels of the nested associative reader.
interface nested_assoc_reader_if #(parameter int unsigned DEPTH = 8);
    import nested_assoc_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic           wr_valid;
    logic           wr_ready;
    logic [K1W-1:0] wr_k1;
    logic [K2W-1:0] wr_k2;
    logic [DW-1:0]  wr_data;
    logic           wr_dropped;
    logic           rd_valid;
    logic           rd_ready;
    logic [1:0]     rd_op;
    logic [K1W-1:0] rd_k1;
    logic [K2W-1:0] rd_k2;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_hit;
    logic [K1W-1:0] rsp_k1;
    logic [K2W-1:0] rsp_k2;
    logic [DW-1:0]  rsp_data;
    logic [CW-1:0]  count;

    modport master (
        output wr_valid, wr_k1, wr_k2, wr_data, rd_valid, rd_op, rd_k1, rd_k2, rsp_ready,
        input  wr_ready, wr_dropped, rd_ready, rsp_valid, rsp_hit, rsp_k1, rsp_k2,
               rsp_data, count
    );

    modport slave (
        input  wr_valid, wr_k1, wr_k2, wr_data, rd_valid, rd_op, rd_k1, rd_k2, rsp_ready,
        output wr_ready, wr_dropped, rd_ready, rsp_valid, rsp_hit, rsp_k1, rsp_k2,
               rsp_data, count
    );

endinterface

// File: rtl/nested_assoc_reader_store.sv
// Slot array with parallel key match, lowest-free allocation, entry count and
// an indexed read mux used by the scanning FSM.
module nested_assoc_store
    import nested_assoc_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [K1W-1:0]               wr_k1_i,
    input  logic [K2W-1:0]               wr_k2_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx_i,
    output entry_t                       rd_entry_c_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         dropped_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [K1W-1:0]   k1_q   [DEPTH];
    logic [K2W-1:0]   k2_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             dropped_q, dropped_d;

    logic          hit_any, free_any, alloc, upd;
    logic [IW-1:0] hit_idx, free_idx, wr_idx;

    // Match and allocation: the first hit / first free slot from index 0 wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit_any && valid_q[i] && k1_q[i] == wr_k1_i && k2_q[i] == wr_k2_i) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!free_any && !valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        upd       = wr_en_i && hit_any;
        alloc     = wr_en_i && !hit_any && free_any;
        wr_idx    = hit_any ? hit_idx : free_idx;
        dropped_d = wr_en_i && !hit_any && !free_any;
        valid_d   = valid_q;
        count_d   = count_q;
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            count_d           = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Key/data payload is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        if (alloc || upd) begin
            k1_q[wr_idx]   <= wr_k1_i;
            k2_q[wr_idx]   <= wr_k2_i;
            data_q[wr_idx] <= wr_data_i;
        end
    end

    always_comb begin
        rd_entry_c_o.valid = valid_q[rd_idx_i];
        rd_entry_c_o.k1    = k1_q[rd_idx_i];
        rd_entry_c_o.k2    = k2_q[rd_idx_i];
        rd_entry_c_o.data  = data_q[rd_idx_i];
    end

    assign count_o   = count_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/nested_assoc_reader.sv
// Two-level associative array reader: write port into the slot store, and a
// fixed-latency scan FSM serving LOOKUP / FIRST / NEXT requests.
module nested_assoc_reader
    import nested_assoc_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nested_assoc_reader_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e         state_q, state_d;
    rd_op_e         op_q, op_d;
    logic [K1W-1:0] req_k1_q, req_k1_d;
    logic [K2W-1:0] req_k2_q, req_k2_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           idle_q, idle_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_hit_q, rsp_hit_d;
    logic [K1W-1:0] rsp_k1_q, rsp_k1_d;
    logic [K2W-1:0] rsp_k2_q, rsp_k2_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;

    entry_t         slot;
    logic           take;
    logic           wr_ready_c;
    logic           wr_en;
    logic [CW-1:0]  count;
    logic           wr_dropped;

    // Reads have priority; a colliding write stays pending.
    assign wr_ready_c = idle_q && !bus.rd_valid;
    assign wr_en      = bus.wr_valid && wr_ready_c;

    nested_assoc_store #(.DEPTH(DEPTH)) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en),
        .wr_k1_i      (bus.wr_k1),
        .wr_k2_i      (bus.wr_k2),
        .wr_data_i    (bus.wr_data),
        .rd_idx_i     (idx_q),
        .rd_entry_c_o (slot),
        .count_o      (count),
        .dropped_o    (wr_dropped)
    );

    // Whether the slot under the scan pointer becomes the new best candidate.
    always_comb begin
        take = 1'b0;
        if (slot.valid) begin
            case (op_q)
                OP_FIRST: take = !rsp_hit_q || key_gt(rsp_k1_q, rsp_k2_q, slot.k1, slot.k2);
                OP_NEXT:  take = key_gt(slot.k1, slot.k2, req_k1_q, req_k2_q) &&
                                 (!rsp_hit_q || key_gt(rsp_k1_q, rsp_k2_q, slot.k1, slot.k2));
                default:  take = (slot.k1 == req_k1_q) && (slot.k2 == req_k2_q);
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        req_k1_d    = req_k1_q;
        req_k2_d    = req_k2_q;
        idx_d       = idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_k1_d    = rsp_k1_q;
        rsp_k2_d    = rsp_k2_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_valid) begin
                    op_d       = rd_op_e'(bus.rd_op);
                    req_k1_d   = bus.rd_k1;
                    req_k2_d   = bus.rd_k2;
                    idx_d      = '0;
                    rsp_hit_d  = 1'b0;
                    rsp_k1_d   = '0;
                    rsp_k2_d   = '0;
                    rsp_data_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (take) begin
                    rsp_hit_d  = 1'b1;
                    rsp_k1_d   = slot.k1;
                    rsp_k2_d   = slot.k2;
                    rsp_data_d = slot.data;
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(DEPTH - 1)) begin
                    idx_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // First RESP cycle publishes the settled candidate.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOOKUP;
            req_k1_q    <= '0;
            req_k2_q    <= '0;
            idx_q       <= '0;
            idle_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_k1_q    <= '0;
            rsp_k2_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_k1_q    <= req_k1_d;
            req_k2_q    <= req_k2_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_k1_q    <= rsp_k1_d;
            rsp_k2_q    <= rsp_k2_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.wr_ready   = wr_ready_c;
    assign bus.rd_ready   = idle_q;
    assign bus.wr_dropped = wr_dropped;
    assign bus.count      = count;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_k1     = rsp_k1_q;
    assign bus.rsp_k2     = rsp_k2_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_nested_assoc_reader.sv
// Self-checking bench for nested_assoc_reader: directed vector table, corner
// sequences, and randomized traffic against an associative-array model.
module tb_nested_assoc_reader;
    import nested_assoc_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    int unsigned model [bit [95:0]];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] k1;
        logic [63:0] k2;
        logic        hit;
        logic [31:0] ek1;
        logic [63:0] ek2;
        logic [31:0] edata;
    } vec_t;
    vec_t vecs[$];

    nested_assoc_reader_if #(.DEPTH(DEPTH)) bus ();

    nested_assoc_reader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model.delete();
    endtask

    // Reference: smallest present key satisfying the op's rule.
    function automatic void ref_read(input logic [1:0] op, input logic [31:0] k1,
                                     input logic [63:0] k2, output logic hit,
                                     output logic [31:0] ek1, output logic [63:0] ek2,
                                     output logic [31:0] ed);
        bit [95:0] req = {k1, k2};
        bit [95:0] best = '0;
        bit found = 1'b0;
        foreach (model[k]) begin
            if (op == 2'd1) begin
                if (!found || k < best) begin best = k; found = 1'b1; end
            end else if (op == 2'd2) begin
                if (k > req && (!found || k < best)) begin best = k; found = 1'b1; end
            end else if (k == req) begin
                best = k; found = 1'b1;
            end
        end
        hit = found;
        ek1 = found ? best[95:64] : 32'd0;
        ek2 = found ? best[63:0] : 64'd0;
        ed  = found ? model[best] : 32'd0;
    endfunction

    task automatic do_write(input logic [31:0] k1, input logic [63:0] k2, input logic [31:0] d);
        bit [95:0] key = {k1, k2};
        bit exp_drop = !model.exists(key) && model.num() >= DEPTH;
        int guard = 0;
        bus.wr_k1 = k1; bus.wr_k2 = k2; bus.wr_data = d; bus.wr_valid = 1'b1;
        while (!bus.wr_ready && guard < 50) begin tick(); guard++; end
        if (guard >= 50) chk("wr_ready_timeout", 128'(0), 128'(1));
        tick();
        bus.wr_valid = 1'b0;
        chk("wr_dropped", 128'(bus.wr_dropped), 128'(exp_drop));
        if (!exp_drop) model[key] = d;
        chk("count_after_write", 128'(bus.count), 128'(model.num()));
    endtask

    task automatic do_read(input logic [1:0] op, input logic [31:0] k1, input logic [63:0] k2,
                           output logic hit, output logic [31:0] rk1, output logic [63:0] rk2,
                           output logic [31:0] rd, output int lat);
        int guard = 0;
        bus.rd_op = op; bus.rd_k1 = k1; bus.rd_k2 = k2; bus.rd_valid = 1'b1;
        while (!bus.rd_ready && guard < 50) begin tick(); guard++; end
        if (guard >= 50) chk("rd_ready_timeout", 128'(0), 128'(1));
        tick();
        bus.rd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        hit = bus.rsp_hit; rk1 = bus.rsp_k1; rk2 = bus.rsp_k2; rd = bus.rsp_data;
        tick();
    endtask

    task automatic read_check(input string tag, input logic [1:0] op,
                              input logic [31:0] k1, input logic [63:0] k2);
        logic eh, h; logic [31:0] ek1, rk1, ed, rd; logic [63:0] ek2, rk2; int lat;
        ref_read(op, k1, k2, eh, ek1, ek2, ed);
        do_read(op, k1, k2, h, rk1, rk2, rd, lat);
        chk({tag, "_hit"}, 128'(h), 128'(eh));
        chk({tag, "_k1"}, 128'(rk1), 128'(ek1));
        chk({tag, "_k2"}, 128'(rk2), 128'(ek2));
        chk({tag, "_data"}, 128'(rd), 128'(ed));
        chk({tag, "_latency"}, 128'(lat), 128'(DEPTH + 1));
    endtask

    task automatic chain_step(input string tag, input logic [1:0] op,
                              input logic [31:0] k1, input logic [63:0] k2,
                              input logic eh, input logic [31:0] ek1, input logic [63:0] ek2,
                              input logic [31:0] ed,
                              output logic [31:0] rk1, output logic [63:0] rk2);
        logic h; logic [31:0] rd; int lat;
        do_read(op, k1, k2, h, rk1, rk2, rd, lat);
        chk({tag, "_hit"}, 128'(h), 128'(eh));
        chk({tag, "_key"}, 128'({rk1, rk2}), 128'({ek1, ek2}));
        chk({tag, "_data"}, 128'(rd), 128'(ed));
    endtask

    initial begin
        logic [31:0] ck1; logic [63:0] ck2;
        logic h; logic [31:0] rk1, rd; logic [63:0] rk2; int lat;
        logic [31:0] k1_pool [4];
        logic [63:0] k2_pool [4];
        bit seen;

        bus.wr_valid = 1'b0; bus.wr_k1 = '0; bus.wr_k2 = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_op = '0; bus.rd_k1 = '0; bus.rd_k2 = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_hit", 128'(bus.rsp_hit), 128'(0));
        chk("rst_rsp_data", 128'(bus.rsp_data), 128'(0));
        chk("rst_count", 128'(bus.count), 128'(0));
        chk("rst_wr_dropped", 128'(bus.wr_dropped), 128'(0));
        chk("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
        chk("rst_rd_ready", 128'(bus.rd_ready), 128'(1));
        chain_step("first_empty", 2'd1, 32'd0, 64'd0, 1'b0, 32'd0, 64'd0, 32'd0, ck1, ck2);

        // Basic lookups via vector table
        do_write(32'd5, 64'd8, 32'd8);
        do_write(32'd5, 64'd9, 32'd9);
        vecs.push_back('{2'd0, 32'd5, 64'd8, 1'b1, 32'd5, 64'd8, 32'd8});
        vecs.push_back('{2'd0, 32'd5, 64'd9, 1'b1, 32'd5, 64'd9, 32'd9});
        vecs.push_back('{2'd0, 32'd5, 64'd7, 1'b0, 32'd0, 64'd0, 32'd0});
        vecs.push_back('{2'd0, 32'd4, 64'd8, 1'b0, 32'd0, 64'd0, 32'd0});
        vecs.push_back('{2'd3, 32'd5, 64'd9, 1'b1, 32'd5, 64'd9, 32'd9});
        vecs.push_back('{2'd1, 32'd7, 64'd7, 1'b1, 32'd5, 64'd8, 32'd8});
        vecs.push_back('{2'd2, 32'd5, 64'd8, 1'b1, 32'd5, 64'd9, 32'd9});
        vecs.push_back('{2'd2, 32'd5, 64'd9, 1'b0, 32'd0, 64'd0, 32'd0});
        foreach (vecs[i]) begin
            do_read(vecs[i].op, vecs[i].k1, vecs[i].k2, h, rk1, rk2, rd, lat);
            chk($sformatf("vec%0d_hit", i), 128'(h), 128'(vecs[i].hit));
            chk($sformatf("vec%0d_key", i), 128'({rk1, rk2}), 128'({vecs[i].ek1, vecs[i].ek2}));
            chk($sformatf("vec%0d_data", i), 128'(rd), 128'(vecs[i].edata));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(DEPTH + 1));
        end
        chk("count_two", 128'(bus.count), 128'(2));
        do_write(32'd5, 64'd8, 32'hDEAD);
        chain_step("overwrite", 2'd0, 32'd5, 64'd8, 1'b1, 32'd5, 64'd8, 32'hDEAD, ck1, ck2);
        chk("count_still_two", 128'(bus.count), 128'(2));

        // Ordered traversal crossing outer keys
        do_reset();
        do_write(32'd6, 64'd0, 32'd1);
        do_write(32'd5, 64'd9, 32'd9);
        do_write(32'd5, 64'd8, 32'd8);
        chain_step("chain_first", 2'd1, 32'd0, 64'd0, 1'b1, 32'd5, 64'd8, 32'd8, ck1, ck2);
        chain_step("chain_next1", 2'd2, ck1, ck2, 1'b1, 32'd5, 64'd9, 32'd9, ck1, ck2);
        chain_step("chain_next2", 2'd2, ck1, ck2, 1'b1, 32'd6, 64'd0, 32'd1, ck1, ck2);
        chain_step("chain_next3", 2'd2, ck1, ck2, 1'b0, 32'd0, 64'd0, 32'd0, ck1, ck2);
        chain_step("next_absent", 2'd2, 32'd5, 64'd100, 1'b1, 32'd6, 64'd0, 32'd1, ck1, ck2);

        // Full table drops the ninth distinct key
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) do_write(32'(i), 64'(i * 3), 32'(100 + i));
        do_write(32'd100, 64'd100, 32'd1);
        tick();
        chk("dropped_one_cycle", 128'(bus.wr_dropped), 128'(0));
        chk("count_full", 128'(bus.count), 128'(DEPTH));
        chain_step("lookup_dropped", 2'd0, 32'd100, 64'd100, 1'b0, 32'd0, 64'd0, 32'd0, ck1, ck2);

        // Response held under backpressure
        bus.rsp_ready = 1'b0;
        bus.rd_op = 2'd0; bus.rd_k1 = 32'd2; bus.rd_k2 = 64'd6; bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        chk("hold_latency", 128'(lat), 128'(DEPTH + 1));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_valid", 128'(bus.rsp_valid), 128'(1));
            chk("hold_payload", 128'({bus.rsp_hit, bus.rsp_k1, bus.rsp_data}),
                128'({1'b1, 32'd2, 32'd102}));
            chk("hold_readies", 128'({bus.rd_ready, bus.wr_ready}), 128'(0));
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("hold_release", 128'(bus.rsp_valid), 128'(0));

        // Simultaneous read and write: read first, write after the response
        do_reset();
        bus.wr_k1 = 32'd7; bus.wr_k2 = 64'd7; bus.wr_data = 32'h77; bus.wr_valid = 1'b1;
        bus.rd_op = 2'd0; bus.rd_k1 = 32'd7; bus.rd_k2 = 64'd7; bus.rd_valid = 1'b1;
        #1;
        chk("collide_wr_ready", 128'(bus.wr_ready), 128'(0));
        tick();
        bus.rd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        chk("collide_read_miss", 128'(bus.rsp_hit), 128'(0));
        chk("collide_count_mid", 128'(bus.count), 128'(0));
        tick();
        lat = 0;
        while (!bus.wr_ready && lat < 10) begin tick(); lat++; end
        tick();
        bus.wr_valid = 1'b0;
        model[{32'd7, 64'd7}] = 32'h77;
        chk("collide_count_after", 128'(bus.count), 128'(1));
        read_check("collide_lookup", 2'd0, 32'd7, 64'd7);

        // Reset during SCAN abandons the request and empties the table
        do_reset();
        do_write(32'd5, 64'd8, 32'd8);
        bus.rd_op = 2'd0; bus.rd_k1 = 32'd5; bus.rd_k2 = 64'd8; bus.rd_valid = 1'b1;
        tick();
        bus.rd_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midscan_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("midscan_count", 128'(bus.count), 128'(0));
        tick();
        rst_n = 1'b1;
        model.delete();
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin tick(); if (bus.rsp_valid) seen = 1'b1; end
        chk("midscan_no_response", 128'(seen), 128'(0));
        read_check("midscan_lookup", 2'd0, 32'd5, 64'd8);

        // Randomized traffic against the model
        k1_pool = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF};
        k2_pool = '{64'd0, 64'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] rk1r; logic [63:0] rk2r;
            rk1r = k1_pool[$urandom_range(0, 3)];
            rk2r = k2_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 0) do_write(rk1r, rk2r, $urandom);
            else read_check($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), rk1r, rk2r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
